// File: rtl/fir_coef_pkg.sv
// rtl/fir_coef_pkg.sv - shared types for the FIR coefficient configuration controller
package fir_coef_pkg;

  localparam int PKG_COEF_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_t;

  typedef logic [PKG_COEF_WIDTH-1:0] coef_t;

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// rtl/fir_coef_ctrl_if.sv - coefficient stream, sample strobe and active-bank bundle
// Readback signals exist only when FIR_COEF_READBACK_EN is defined.
interface fir_coef_ctrl_if #(
  parameter int FIR_LENGTH = 51,
  parameter int COEF_WIDTH = 16
);
  localparam int ADDR_WIDTH = (FIR_LENGTH > 1) ? $clog2(FIR_LENGTH) : 1;

  logic                             i_load_start;
  logic                             i_coef_valid;
  logic [COEF_WIDTH-1:0]            i_coef_data;
  logic                             o_coef_ready;
  logic                             i_sample_valid;
  logic [FIR_LENGTH*COEF_WIDTH-1:0] o_coefs;
  logic                             o_busy;
  logic                             o_swap_done;
  logic                             o_err;
`ifdef FIR_COEF_READBACK_EN
  logic [ADDR_WIDTH-1:0]            i_rd_addr;
  logic [COEF_WIDTH-1:0]            o_rd_data;
`endif

  modport master (
    output i_load_start, i_coef_valid, i_coef_data, i_sample_valid,
    input  o_coef_ready, o_coefs, o_busy, o_swap_done, o_err
`ifdef FIR_COEF_READBACK_EN
    , output i_rd_addr
    , input  o_rd_data
`endif
  );

  modport slave (
    input  i_load_start, i_coef_valid, i_coef_data, i_sample_valid,
    output o_coef_ready, o_coefs, o_busy, o_swap_done, o_err
`ifdef FIR_COEF_READBACK_EN
    , input  i_rd_addr
    , output o_rd_data
`endif
  );

endinterface

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - one coefficient bank: single write port, flattened read-all output
module fir_coef_bank #(
  parameter int FIR_LENGTH = 51,
  parameter int COEF_WIDTH = 16,
  parameter int ADDR_WIDTH = (FIR_LENGTH > 1) ? $clog2(FIR_LENGTH) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_we,
  input  logic [ADDR_WIDTH-1:0]            i_addr,
  input  logic [COEF_WIDTH-1:0]            i_data,
  output logic [FIR_LENGTH*COEF_WIDTH-1:0] o_coefs
);

  for (genvar i = 0; i < FIR_LENGTH; i++) begin : g_tap
    logic [COEF_WIDTH-1:0] word_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        word_q <= '0;
      end else if (i_we && (i_addr == ADDR_WIDTH'(i))) begin
        word_q <= i_data;
      end
    end

    assign o_coefs[i*COEF_WIDTH +: COEF_WIDTH] = word_q;
  end

endmodule

// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - double-buffered FIR coefficient loader with sample-aligned bank swap
// Optional shadow readback port built when FIR_COEF_READBACK_EN is defined.
module fir_coef_ctrl
  import fir_coef_pkg::*;
#(
  parameter int FIR_LENGTH = 51,
  parameter int COEF_WIDTH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fir_coef_ctrl_if.slave bus
);

  localparam int ADDR_WIDTH = (FIR_LENGTH > 1) ? $clog2(FIR_LENGTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FIR_LENGTH - 1);

  state_t                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            idx_q, idx_d;
  logic                             bank_sel_q;
  logic                             swap_done_q;
  logic                             err_q;
  logic                             do_swap;
  logic                             do_err;
  logic                             wr_en;
  logic [FIR_LENGTH*COEF_WIDTH-1:0] bank0_coefs;
  logic [FIR_LENGTH*COEF_WIDTH-1:0] bank1_coefs;

  // A start in LOAD restarts the session, so the word presented with it is dropped.
  assign wr_en = (state_q == ST_LOAD) && bus.i_coef_valid && !bus.i_load_start;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    do_swap = 1'b0;
    do_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (bus.i_load_start) begin
          idx_d  = '0;
          do_err = 1'b1;
        end else if (bus.i_coef_valid) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_WAIT_SWAP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_WAIT_SWAP: begin
        if (bus.i_sample_valid) begin
          state_d = ST_IDLE;
          do_swap = 1'b1;
          do_err  = bus.i_load_start;
        end else if (bus.i_load_start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          do_err  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      bank_sel_q  <= 1'b0;
      swap_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bank_sel_q  <= bank_sel_q ^ do_swap;
      swap_done_q <= do_swap;
      err_q       <= do_err;
    end
  end

  // Writes always land in the bank that is not currently driving the multipliers.
  fir_coef_bank #(
    .FIR_LENGTH (FIR_LENGTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (wr_en && bank_sel_q),
    .i_addr  (idx_q),
    .i_data  (bus.i_coef_data),
    .o_coefs (bank0_coefs)
  );

  fir_coef_bank #(
    .FIR_LENGTH (FIR_LENGTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (wr_en && !bank_sel_q),
    .i_addr  (idx_q),
    .i_data  (bus.i_coef_data),
    .o_coefs (bank1_coefs)
  );

  assign bus.o_coefs      = bank_sel_q ? bank1_coefs : bank0_coefs;
  assign bus.o_coef_ready = (state_q == ST_LOAD);
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_swap_done  = swap_done_q;
  assign bus.o_err        = err_q;

`ifdef FIR_COEF_READBACK_EN
  logic [FIR_LENGTH*COEF_WIDTH-1:0] shadow_coefs;
  logic [COEF_WIDTH-1:0]            rd_word;
  logic [COEF_WIDTH-1:0]            rd_data_q;

  assign shadow_coefs = bank_sel_q ? bank0_coefs : bank1_coefs;

  // Unmatched (out-of-range) addresses fall through to zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < FIR_LENGTH; i++) begin
      if (bus.i_rd_addr == ADDR_WIDTH'(i)) begin
        rd_word = shadow_coefs[i*COEF_WIDTH +: COEF_WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_word;
    end
  end

  assign bus.o_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb/tb_fir_coef_ctrl.sv - scoreboard bench for fir_coef_ctrl with a behavioural bank model
module tb_fir_coef_ctrl;
  import fir_coef_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_coef_ctrl_if #(.FIR_LENGTH(N), .COEF_WIDTH(16)) bus ();

  fir_coef_ctrl #(.FIR_LENGTH(N), .COEF_WIDTH(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: two coefficient arrays plus session flags.
  coef_t m_active [N];
  coef_t m_shadow [N];
  bit    m_loading;
  bit    m_pending;
  int    m_count;
  bit    exp_err_now;
  bit    exp_swap_now;
  logic [N*16-1:0] swap_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*16-1:0] pack_active();
    logic [N*16-1:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = m_active[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = '0;
      m_shadow[i] = '0;
    end
    m_loading    = 0;
    m_pending    = 0;
    m_count      = 0;
    exp_err_now  = 0;
    exp_swap_now = 0;
    swap_q.delete();
  endtask

  task automatic model_step(input bit st, input bit v, input coef_t d, input bit s);
    coef_t tmp;
    exp_err_now  = 0;
    exp_swap_now = 0;
    if (m_pending) begin
      if (s) begin
        for (int i = 0; i < N; i++) begin
          tmp         = m_active[i];
          m_active[i] = m_shadow[i];
          m_shadow[i] = tmp;
        end
        m_pending    = 0;
        exp_swap_now = 1;
        exp_err_now  = st;
        swap_q.push_back(pack_active());
      end else if (st) begin
        m_pending   = 0;
        m_loading   = 1;
        m_count     = 0;
        exp_err_now = 1;
      end
    end else if (m_loading) begin
      if (st) begin
        m_count     = 0;
        exp_err_now = 1;
      end else if (v) begin
        m_shadow[m_count] = d;
        m_count++;
        if (m_count == N) begin
          m_loading = 0;
          m_pending = 1;
        end
      end
    end else if (st) begin
      m_loading = 1;
      m_count   = 0;
    end
  endtask

  task automatic cyc(input bit st, input bit v, input coef_t d, input bit s);
    bus.i_load_start   = st;
    bus.i_coef_valid   = v;
    bus.i_coef_data    = d;
    bus.i_sample_valid = s;
    @(posedge clk);
    model_step(st, v, d, s);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0);
  endtask

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("coefs", bus.o_coefs, pack_active());
      chk("coef_ready", bus.o_coef_ready, m_loading);
      chk("busy", bus.o_busy, m_loading | m_pending);
      chk("swap_done", bus.o_swap_done, exp_swap_now);
      chk("err", bus.o_err, exp_err_now);
      if (bus.o_swap_done) begin
        if (swap_q.size() == 0) chk("swap_unexpected", 1, 0);
        else chk("swap_coefs", bus.o_coefs, swap_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    bus.i_load_start   = 0;
    bus.i_coef_valid   = 0;
    bus.i_coef_data    = '0;
    bus.i_sample_valid = 0;
`ifdef FIR_COEF_READBACK_EN
    bus.i_rd_addr      = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_coefs", bus.o_coefs, 64'h0);
    chk("rst_ready", bus.o_coef_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_swap_done", bus.o_swap_done, 0);
    chk("rst_err", bus.o_err, 0);
    rst = 0;
    idle(2);

    // Back-to-back load, strobe three cycles later.
    cyc(1, 0, 16'h0, 0);
    for (int k = 1; k <= N; k++) cyc(0, 1, coef_t'(k), 0);
    idle(3);
    chk("pre_swap_coefs", bus.o_coefs, 64'h0);
    cyc(0, 0, 16'h0, 1);
    chk("swap1_coefs", bus.o_coefs, 64'h0004_0003_0002_0001);
    idle(2);

    // Gapped load, long wait without strobe.
    cyc(1, 0, 16'h0, 0);
    for (int k = 1; k <= N; k++) begin
      cyc(0, 1, coef_t'(16 * k), 0);
      idle(1);
    end
    idle(20);
    chk("wait_busy", bus.o_busy, 1);
    chk("wait_coefs", bus.o_coefs, 64'h0004_0003_0002_0001);
    cyc(0, 0, 16'h0, 1);
    idle(1);
    chk("swap2_coefs", bus.o_coefs, 64'h0040_0030_0020_0010);

    // Restart mid-load with a word presented on the restart cycle.
    cyc(1, 0, 16'h0, 0);
    cyc(0, 1, 16'h1234, 0);
    cyc(0, 1, 16'h5678, 0);
    cyc(1, 1, 16'hDEAD, 0);
    for (int k = 0; k < N; k++) cyc(0, 1, 16'hAAAA, 0);
    cyc(0, 0, 16'h0, 1);
    idle(1);
    chk("restart_coefs", bus.o_coefs, {4{16'hAAAA}});

    // Start and strobe together in WAIT_SWAP: swap wins.
    cyc(1, 0, 16'h0, 0);
    for (int k = 1; k <= N; k++) cyc(0, 1, coef_t'(16'h1111 * k), 0);
    cyc(1, 0, 16'h0, 1);
    chk("collide_err", bus.o_err, 1);
    chk("collide_busy", bus.o_busy, 0);
    chk("collide_coefs", bus.o_coefs, 64'h4444_3333_2222_1111);
    idle(2);

    // WAIT_SWAP cancelled by a new start, then a fresh load.
    cyc(1, 0, 16'h0, 0);
    for (int k = 0; k < N; k++) cyc(0, 1, 16'h0BAD, 0);
    cyc(1, 0, 16'h0, 0);
    for (int k = 1; k <= N; k++) cyc(0, 1, coef_t'(k + 16'h0100), 0);
    cyc(0, 0, 16'h0, 1);
    idle(1);
    chk("cancel_coefs", bus.o_coefs, 64'h0104_0103_0102_0101);

    // Asynchronous reset in the middle of a load.
    cyc(1, 0, 16'h0, 0);
    cyc(0, 1, 16'h7777, 0);
    cyc(0, 1, 16'h8888, 0);
    #3 rst = 1;
    #1;
    chk("async_rst_coefs", bus.o_coefs, 64'h0);
    model_reset();
    bus.i_load_start = 0;
    bus.i_coef_valid = 0;
    bus.i_sample_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("post_rst_ready", bus.o_coef_ready, 0);
    chk("post_rst_busy", bus.o_busy, 0);
    @(posedge clk);
    model_step(0, 0, 16'h0, 0);
    #1;

    // Randomised traffic against the model.
    for (int c = 0; c < 800; c++) begin
      cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
          coef_t'($urandom), ($urandom_range(0, 7) == 0));
    end
    idle(3);
    chk("swap_q_empty", swap_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coef_ctrl.md
Name: fir_coef_ctrl

Overview:
- Run-time coefficient configuration controller for the transposed-form low-pass FIR datapath.
- Accepts a coefficient stream over a valid/ready handshake into a shadow bank of a double-buffered coefficient store.
- Swaps shadow and active banks only on a sample boundary, so the filter never runs a sample on a mixed coefficient set.
- Drives the flattened active coefficient vector into the FIR multipliers.

Parameters:
- FIR_LENGTH, 51, number of taps (coefficients per bank).
- COEF_WIDTH, 16, coefficient width in bits (two's complement, passed through unmodified).
- ADDR_WIDTH, $clog2(FIR_LENGTH), local derived width of the write index. Not overridable.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_load_start  in  1  single-cycle request to begin a load session.
- i_coef_valid  in  1  coefficient word valid.
- i_coef_data  in  COEF_WIDTH  coefficient word; stream order is tap 0 first.
- o_coef_ready  out  1  controller accepts a coefficient word.
- i_sample_valid  in  1  FIR sample strobe; marks a sample boundary.
- o_coefs  out  FIR_LENGTH*COEF_WIDTH  active bank; tap i is at [i*COEF_WIDTH +: COEF_WIDTH].
- o_busy  out  1  high in LOAD or WAIT_SWAP.
- o_swap_done  out  1  one-cycle pulse on the cycle after a bank swap.
- o_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async assert): both banks all-zero, bank select = 0, state IDLE, write index 0. o_coefs = 0, o_coef_ready = 0, o_busy = 0, o_swap_done = 0, o_err = 0.
- Reset mid-load or mid-wait: discards the session. Active coefficients return to zero.
- All outputs are registered or decoded directly from registered state.
- FSM states: IDLE, LOAD, WAIT_SWAP.
- IDLE:
  - o_coef_ready = 0.
  - i_load_start -> LOAD, index <= 0.
  - i_coef_valid in IDLE is ignored with no error.
- LOAD:
  - o_coef_ready = 1.
  - Each cycle with valid & ready writes shadow[index] <= i_coef_data, then index++.
  - The write at index == FIR_LENGTH-1 -> WAIT_SWAP. o_coef_ready drops on the next cycle.
- WAIT_SWAP:
  - o_coef_ready = 0.
  - First cycle with i_sample_valid: bank select toggles and state -> IDLE.
  - o_coefs shows the new bank and o_swap_done pulses on the following cycle (1-cycle latency from the strobe edge).
- i_load_start in LOAD: restart. Index <= 0, partial shadow contents are overwritten, o_err pulses. If a valid word is present that same cycle, it is dropped (not written).
- i_load_start in WAIT_SWAP without i_sample_valid: pending swap is cancelled, -> LOAD, index <= 0, o_err pulses.
- i_load_start and i_sample_valid together in WAIT_SWAP: the swap wins, the start is dropped, o_err pulses, -> IDLE.
- i_sample_valid in IDLE or LOAD: no effect on banks.
- Active bank is never written. The shadow bank is never visible on o_coefs.
- Index wrap: the index never exceeds FIR_LENGTH-1. No write is possible outside LOAD.

Optional Feature:
- Macro: FIR_COEF_READBACK_EN.
- Defined:
  - Adds ports i_rd_addr (in, ADDR_WIDTH) and o_rd_data (out, COEF_WIDTH).
  - o_rd_data is registered with 1-cycle latency and returns shadow[i_rd_addr].
  - Addresses >= FIR_LENGTH return 0. Reset value of o_rd_data is 0.
  - Intended for host verification of a load before the swap.
- Undefined: the ports are absent and no readback logic is built.

Decomposition:
- Package fir_coef_pkg:
  - state enum type (IDLE, LOAD, WAIT_SWAP).
  - coefficient word typedef parameterised by COEF_WIDTH via a localparam default of 16.
- Sub-module fir_coef_bank:
  - FIR_LENGTH x COEF_WIDTH register array, async reset to zero.
  - Single write port (we, addr, data) and a flattened read-all output.
  - Instanced twice. The controller muxes o_coefs by bank select and routes writes to the non-selected bank.

Test Plan (FIR_LENGTH=4, COEF_WIDTH=16 override):
- Reset then idle -> o_coefs = 0, o_coef_ready = 0, o_busy = 0.
- Start; stream 0x0001,0x0002,0x0003,0x0004 back-to-back; strobe i_sample_valid 3 cycles later -> o_coefs unchanged until the cycle after the strobe, then taps = 1,2,3,4; o_swap_done pulses once.
- Load 0x0010..0x0040 with valid gaps and no strobe for 20 cycles -> o_coefs stays 1,2,3,4 and o_busy = 1. Then strobe -> taps = 0x10,0x20,0x30,0x40.
- Restart after 2 words (start during LOAD), then send 0xAAAA x4 and strobe -> o_err pulses once; all taps = 0xAAAA.
- In WAIT_SWAP, assert start and i_sample_valid in the same cycle -> swap occurs, o_err = 1 for one cycle, state returns to IDLE.
- Assert i_rst during LOAD after a prior swap -> o_coefs = 0 immediately (async); after release, o_coef_ready = 0.
